// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - port identifiers (core load/store unit vs. loader/IO DMA)
//   - the response-pipe record carried from grant to response
//   - addr_ok(): legality check for a byte address against the memory size
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef logic port_t;

    localparam port_t PORT_CORE = 1'b0;
    localparam port_t PORT_DMA  = 1'b1;

    // One entry of the single-stage response pipe.
    typedef struct packed {
        logic  valid;
        port_t port;
        logic  is_read;
        logic  err;
    } rsp_t;

    // Word-aligned and inside a 2**addrw byte memory. The full 32-bit
    // address is checked, so upper bits can never alias onto low memory.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addrw);
        logic [31:0] upper;
        upper = addr >> addrw;
        return (upper == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports and the memory-side signals of dmem_arbiter.
//   slave  : the arbiter's view (takes requests, drives grants/responses and
//            the memory inputs, receives mem_dout)
//   master : the environment's view (requesters plus the memory itself)
// Signals per requester N=0,1:
//   pN_req/pN_we/pN_addr/pN_wdata  request, held stable until pN_gnt
//   pN_gnt                         combinational grant
//   pN_rvalid/pN_rdata/pN_err      one-cycle response pulse
// Memory side: mem_we, mem_addr, mem_din (to memory), mem_dout (from memory).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Stateless winner select between two requesters.
//   req0, req1 : requests from port 0 / port 1
//   prefer1    : tie-break toward port 1 (round-robin pointer or the
//                anti-starvation promotion, depending on build)
//   gnt0, gnt1 : one-hot-or-zero grants
// -----------------------------------------------------------------------------
module dmem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic prefer1,
    output logic gnt0,
    output logic gnt1
);

    assign gnt1 = req1 & (~req0 | prefer1);
    assign gnt0 = req0 & ~gnt1;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the core load/store unit (port 0)
// and the loader/IO DMA (port 1). One access is granted per cycle; its
// response (read data or write ack, or an error for illegal addresses) comes
// back on the granted port one cycle later.
//
// Build option: DMEM_ARB_RR_EN
//   defined   -> round-robin arbitration (the tie goes to the port that was
//                not granted last)
//   undefined -> fixed priority for port 0, with port 1 promoted once after
//                MAX_WAIT consecutive denied cycles
//
// Ports:
//   clk   : clock, all state on posedge
//   rstn  : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (requesters + memory side)
// Parameters:
//   ADDRW    : byte-address width of the memory
//   MAX_WAIT : denied cycles before port 1 is promoted (fixed mode, >= 1)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRW    = 10,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    dmem_arbiter_if.slave        bus
);

    logic prefer1;
    logic gnt0;
    logic gnt1;

    dmem_arb_pick u_pick (
        .req0    (bus.p0_req),
        .req1    (bus.p1_req),
        .prefer1 (prefer1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

`ifdef DMEM_ARB_RR_EN
    // rr_ptr names the port that wins the next tie; it starts at port 0 and
    // flips to the other port after each grant.
    port_t rr_ptr;

    assign prefer1 = (rr_ptr == PORT_DMA);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= PORT_CORE;
        end else if (gnt0) begin
            rr_ptr <= PORT_DMA;
        end else if (gnt1) begin
            rr_ptr <= PORT_CORE;
        end
    end
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    assign prefer1 = (wait_cnt == WAIT_MAX);

    // Counts consecutive cycles port 1 is kept waiting; any p1 grant or a
    // dropped request starts the count over.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (!bus.p1_req || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // Stage p0: select the granted port's fields and drive the memory.
    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_ok;

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    assign sel_ok    = addr_ok(sel_addr, ADDRW);

    assign bus.p0_gnt   = gnt0;
    assign bus.p1_gnt   = gnt1;
    // Illegal accesses still present their address but never write.
    assign bus.mem_we   = any_gnt & sel_we & sel_ok;
    assign bus.mem_addr = sel_addr;
    assign bus.mem_din  = sel_wdata;

    // Stage p1: response record, aligned with mem_dout of the accepted access.
    rsp_t rsp_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_p1 <= '0;
        end else begin
            rsp_p1.valid   <= any_gnt;
            rsp_p1.port    <= gnt1 ? PORT_DMA : PORT_CORE;
            rsp_p1.is_read <= ~sel_we;
            rsp_p1.err     <= ~sel_ok;
        end
    end

    logic rvalid0;
    logic rvalid1;
    logic rdata_en;

    assign rvalid0  = rsp_p1.valid & (rsp_p1.port == PORT_CORE);
    assign rvalid1  = rsp_p1.valid & (rsp_p1.port == PORT_DMA);
    assign rdata_en = rsp_p1.is_read & ~rsp_p1.err;

    assign bus.p0_rvalid = rvalid0;
    assign bus.p0_err    = rvalid0 & rsp_p1.err;
    assign bus.p0_rdata  = (rvalid0 & rdata_en) ? bus.mem_dout : 32'd0;

    assign bus.p1_rvalid = rvalid1;
    assign bus.p1_err    = rvalid1 & rsp_p1.err;
    assign bus.p1_rdata  = (rvalid1 & rdata_en) ? bus.mem_dout : 32'd0;

endmodule
